ghostbus_arb: RTL and testbench

Two-requester arbiter that shares one ghostbus host port between independent masters, e.g. a UART bridge and an Ethernet bridge, both feeding the same decoded register tree under `top`. Each requester presents a level-held transaction and receives a one-cycle acknowledge. The block sequences each transaction onto `gb_addr`/`gb_wdata`/`gb_wen`/`gb_rstb` and waits out the fixed read latency before returning `gb_rdata`. Requesters are granted round-robin by default.

---
 rtl/ghostbus_arb.sv | 123 ++++++++++++
 tb/tb_ghostbus_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_arb.sv
// Two-requester arbiter sharing one ghostbus host port (round-robin by default).
// Define GHOSTBUS_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead.
module ghostbus_arb #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32,
  parameter int unsigned RD = 8
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StXfer, StWait, StAck} state_e;

  localparam logic [7:0] CntLoad = 8'(RD - 1);

  state_e     state_q;
  logic       grant_q;
  logic [7:0] cnt_q;
  logic       any_req;
  logic       pick;

  assign any_req = req0 | req1;

`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever present; otherwise only requester 1 can be asking.
  assign pick = ~req0;
`else
  logic last_grant_q;
  assign pick = (req0 & req1) ? ~last_grant_q : req1;
`endif

  assign busy = (state_q != StIdle);

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      gb_addr      <= '0;
      gb_wdata     <= '0;
      gb_wen       <= 1'b0;
      gb_rstb      <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
`ifndef GHOSTBUS_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      gb_wen  <= 1'b0;
      gb_rstb <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q  <= pick;
            gb_addr  <= pick ? addr1 : addr0;
            gb_wdata <= pick ? wdata1 : wdata0;
            if (pick ? we1 : we0) begin
              gb_wen <= 1'b1;
            end else begin
              gb_rstb <= 1'b1;
            end
            state_q <= StXfer;
          end
        end
        StXfer: begin
          // gb_wen is only ever high in XFER for a write, so it doubles as the latched we.
          if (gb_wen) begin
            ack0    <= ~grant_q;
            ack1    <= grant_q;
            state_q <= StAck;
          end else begin
            cnt_q   <= CntLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (grant_q) begin
              rdata1 <= gb_rdata;
            end else begin
              rdata0 <= gb_rdata;
            end
            ack0    <= ~grant_q;
            ack1    <= grant_q;
            state_q <= StAck;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StAck: begin
`ifndef GHOSTBUS_ARB_FIXED_PRIO_EN
          last_grant_q <= grant_q;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ghostbus_arb.sv
// Self-checking bench for ghostbus_arb: directed scenarios plus randomized traffic,
// compared each cycle against a transaction-timing reference model.
module tb_ghostbus_arb;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RD = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          gb_clk = 1'b0;
  logic          gb_rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, gb_wen, gb_rstb, busy;
  logic [DW-1:0] rdata0, rdata1, gb_wdata;
  logic [DW-1:0] gb_rdata = '0;
  logic [AW-1:0] gb_addr;

  ghostbus_arb #(.AW(AW), .DW(DW), .RD(RD)) dut (
    .gb_clk  (gb_clk),
    .gb_rst_n(gb_rst_n),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .ack0    (ack0),
    .ack1    (ack1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .gb_addr (gb_addr),
    .gb_wdata(gb_wdata),
    .gb_wen  (gb_wen),
    .gb_rstb (gb_rstb),
    .gb_rdata(gb_rdata),
    .busy    (busy)
  );

  always #5 gb_clk = ~gb_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_fill = 0;

  // Reference model: one transaction in flight, described by its start cycle and
  // the arithmetic strobe/ack cycles that follow from it.
  bit            m_active;
  int            m_t, m_ack, m_free, m_win, m_last, last_t;
  logic          m_we;
  logic [AW-1:0] m_addr, m_gb_addr;
  logic [DW-1:0] m_gb_wdata;
  logic [DW-1:0] m_rdata [2];

  txn_t todo0[$], todo1[$];
  int   ack_log[$], ack_cyc_log[$], rstb_log[$];
  logic [DW-1:0] rd0_log[$];
  int   wen_cnt, wen_cyc;
  logic [AW-1:0] wen_addr, due_addr;
  logic [DW-1:0] wen_data;
  int   due = -1;

  function automatic logic [DW-1:0] bus_val(input logic [AW-1:0] a);
    if (a == 24'h000020) return 32'h12345678;
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_free = 0; m_last = 1;
    m_gb_addr = '0; m_gb_wdata = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
  endtask

  task automatic clear_logs();
    ack_log.delete(); ack_cyc_log.delete(); rstb_log.delete(); rd0_log.delete();
    wen_cnt = 0;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we = 1'($urandom);
    t.addr = AW'($urandom);
    t.wdata = $urandom;
    return t;
  endfunction

  task automatic drive();
    if (rand_fill && todo0.size() < 2 && $urandom_range(0, 3) == 0) todo0.push_back(rand_txn());
    if (rand_fill && todo1.size() < 2 && $urandom_range(0, 3) == 0) todo1.push_back(rand_txn());
    req0 = (todo0.size() != 0);
    req1 = (todo1.size() != 0);
    if (req0) begin we0 = todo0[0].we; addr0 = todo0[0].addr; wdata0 = todo0[0].wdata; end
    if (req1) begin we1 = todo1[0].we; addr1 = todo1[0].addr; wdata1 = todo1[0].wdata; end
  endtask

  // Advance one cycle, compare every output with the model, then react as the environment.
  task automatic tick_check();
    logic [1:0] exp_ack;
    logic exp_wen, exp_rstb, exp_busy;
    @(posedge gb_clk);
    #1;
    cyc++;
    exp_ack = '0; exp_wen = 0; exp_rstb = 0; exp_busy = 0;
    if (m_active) begin
      if (cyc == m_t + 1) begin exp_wen = m_we; exp_rstb = !m_we; end
      exp_busy = (cyc > m_t) && (cyc <= m_ack);
      if (cyc == m_ack) begin
        exp_ack[m_win] = 1'b1;
        if (!m_we) m_rdata[m_win] = bus_val(m_addr);
      end
    end
    chk("gb_wen", gb_wen, exp_wen);
    chk("gb_rstb", gb_rstb, exp_rstb);
    chk("ack0", ack0, exp_ack[0]);
    chk("ack1", ack1, exp_ack[1]);
    chk("busy", busy, exp_busy);
    chk("gb_addr", gb_addr, m_gb_addr);
    chk("gb_wdata", gb_wdata, m_gb_wdata);
    chk("rdata0", rdata0, m_rdata[0]);
    chk("rdata1", rdata1, m_rdata[1]);
    if (m_active && cyc == m_ack) begin
      m_active = 0;
      m_last = m_win;
    end
    if (gb_wen) begin wen_cnt++; wen_cyc = cyc; wen_addr = gb_addr; wen_data = gb_wdata; end
    if (gb_rstb) begin rstb_log.push_back(cyc); due = cyc + RD; due_addr = gb_addr; end
    if (ack0) begin
      ack_log.push_back(0); ack_cyc_log.push_back(cyc); rd0_log.push_back(rdata0);
      if (todo0.size() != 0) todo0.delete(0);
    end
    if (ack1) begin
      ack_log.push_back(1); ack_cyc_log.push_back(cyc);
      if (todo1.size() != 0) todo1.delete(0);
    end
    gb_rdata = (cyc == due) ? bus_val(due_addr) : DW'($urandom);
    drive();
  endtask

  task automatic decide();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!gb_rst_n || m_active || cyc < m_free || !(req0 || req1)) return;
    if (req0 && req1) begin
`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
      m_win = 0;
`else
      m_win = 1 - m_last;
`endif
    end else begin
      m_win = req1 ? 1 : 0;
    end
    m_we = m_win ? we1 : we0;
    a = m_win ? addr1 : addr0;
    d = m_win ? wdata1 : wdata0;
    m_addr = a; m_gb_addr = a; m_gb_wdata = d;
    m_t = cyc; last_t = cyc;
    m_ack = cyc + (m_we ? 2 : 2 + RD);
    m_free = m_ack + 1;
    m_active = 1;
  endtask

  task automatic run_drain(input int max);
    int k = 0;
    while ((todo0.size() != 0 || todo1.size() != 0 || m_active) && k < max) begin
      tick_check(); decide(); k++;
    end
    chk("drain_within_budget", k < max, 1);
    tick_check(); decide();
  endtask

  initial begin
    int acks_before, k;
    txn_t t;
    model_reset();
    #1 gb_rst_n = 0;
    #2;
    chk("rst_ack0", ack0, 0); chk("rst_ack1", ack1, 0); chk("rst_busy", busy, 0);
    chk("rst_gb_wen", gb_wen, 0); chk("rst_gb_rstb", gb_rstb, 0);
    chk("rst_gb_addr", gb_addr, 0); chk("rst_gb_wdata", gb_wdata, 0);
    chk("rst_rdata0", rdata0, 0); chk("rst_rdata1", rdata1, 0);
    tick_check();
    #4 gb_rst_n = 1;
    decide();

    // Single write from requester 0
    clear_logs();
    t.we = 1; t.addr = 24'h000010; t.wdata = 32'hDEADBEEF; todo0.push_back(t);
    run_drain(20);
    chk("wr_wen_pulses", wen_cnt, 1);
    chk("wr_addr", wen_addr, 24'h000010);
    chk("wr_data", wen_data, 32'hDEADBEEF);
    chk("wr_ack_count", ack_log.size(), 1);
    if (ack_log.size() == 1) begin
      chk("wr_ack_port", ack_log[0], 0);
      chk("wr_ack_after_wen", ack_cyc_log[0] - wen_cyc, 1);
    end

    // Single read from requester 1
    clear_logs();
    t.we = 0; t.addr = 24'h000020; t.wdata = 32'h0; todo1.push_back(t);
    run_drain(40);
    chk("rd_ack_count", ack_log.size(), 1);
    if (ack_log.size() == 1) chk("rd_ack_latency", ack_cyc_log[0] - last_t, 10);
    chk("rd_rdata1", rdata1, 32'h12345678);

    // Both requesters writing continuously
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      t = rand_txn(); t.we = 1; todo0.push_back(t);
      t = rand_txn(); t.we = 1; todo1.push_back(t);
    end
    run_drain(60);
    chk("alt_ack_count", ack_log.size(), 8);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
`ifdef GHOSTBUS_ARB_FIXED_PRIO_EN
      chk("alt_grant_order", ack_log[i], 0);
`else
      chk("alt_grant_order", ack_log[i], i % 2);
`endif
    end

    // Back-to-back reads from requester 0 with req held
    clear_logs();
    t.we = 0; t.wdata = 32'h0;
    t.addr = 24'h000004; todo0.push_back(t);
    t.addr = 24'h000008; todo0.push_back(t);
    run_drain(60);
    chk("b2b_rstb_count", rstb_log.size(), 2);
    if (rstb_log.size() == 2) chk("b2b_rstb_spacing", rstb_log[1] - rstb_log[0], 11);
    chk("b2b_ack_count", rd0_log.size(), 2);
    if (rd0_log.size() == 2) begin
      chk("b2b_rdata_a4", rd0_log[0], bus_val(24'h000004));
      chk("b2b_rdata_a8", rd0_log[1], bus_val(24'h000008));
    end

    // Reset asserted while a read is waiting for data
    clear_logs();
    t.we = 0; t.addr = 24'h000040; todo0.push_back(t);
    k = 0;
    while (rstb_log.size() == 0 && k < 20) begin tick_check(); decide(); k++; end
    chk("rst_wait_saw_rstb", rstb_log.size(), 1);
    repeat (3) begin tick_check(); decide(); end
    chk("rst_wait_busy", busy, 1);
    #2 gb_rst_n = 0;
    model_reset(); todo0.delete(); todo1.delete(); drive();
    #1;
    chk("mid_rst_ack0", ack0, 0); chk("mid_rst_ack1", ack1, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gb_wen", gb_wen, 0); chk("mid_rst_gb_rstb", gb_rstb, 0);
    chk("mid_rst_gb_addr", gb_addr, 0); chk("mid_rst_gb_wdata", gb_wdata, 0);
    chk("mid_rst_rdata0", rdata0, 0); chk("mid_rst_rdata1", rdata1, 0);
    acks_before = ack_log.size();
    repeat (3) tick_check();
    #4 gb_rst_n = 1;
    decide();
    chk("mid_rst_no_ack", ack_log.size(), acks_before);
    t = rand_txn(); t.we = 1; todo1.push_back(t);
    t = rand_txn(); t.we = 1; todo0.push_back(t);
    run_drain(30);
    chk("post_rst_ack_count", ack_log.size(), acks_before + 2);
    if (ack_log.size() > acks_before) chk("post_rst_first_grant", ack_log[acks_before], 0);

    // Randomized traffic from both requesters
    rand_fill = 1;
    repeat (2000) begin tick_check(); decide(); end
    rand_fill = 0;
    run_drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
